// File: rtl/mult16_seq.sv
// Sequential 16x16 unsigned shift-and-add multiplier with a 16-bit ripple-carry adder.
// Optional build macro MULT16_ZERO_SKIP_EN: zero operands finish in one cycle.

// fulladd16: 16-bit ripple-carry adder
// Latency: combinational
// Backpressure: none
module fulladd16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [16:0] c;

  assign c[0] = cin;

  genvar i;
  generate
    for (i = 0; i < 16; i++) begin : g_bit
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  endgenerate

  assign cout = c[16];
endmodule

// mult16_seq: 16x16 -> 32 unsigned multiply, one adder pass per clock
// Latency: done 16 cycles after the accepting edge (1 with zero skip)
// Backpressure: start is ignored while busy; no queuing
module mult16_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [15:0] mcand;
  logic [15:0] acc;
  logic [15:0] mq;
  logic [3:0]  cnt;

  logic [15:0] addend;
  logic [15:0] sum;
  logic        cout;
  logic [15:0] next_acc;
  logic [15:0] next_mq;

  assign addend = mq[0] ? mcand : 16'h0000;

  fulladd16 u_add (
    .a    (acc),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // The adder carry-out lands in acc[15]; sum[0] drops into the low product.
  assign next_acc = {cout, sum[15:1]};
  assign next_mq  = {sum[0], mq[15:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      acc     <= '0;
      mq      <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= a;
            mq    <= b;
            acc   <= '0;
            cnt   <= '0;
`ifdef MULT16_ZERO_SKIP_EN
            if (a == 16'h0000 || b == 16'h0000) begin
              state   <= DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
              product <= '0;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
`else
            state <= RUN;
            busy  <= 1'b1;
`endif
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          acc <= next_acc;
          mq  <= next_mq;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            product <= {next_acc, next_mq};
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule
